// File: rtl/multicycle_alu_unit.sv
// multicycle_alu_unit: ALU-control decode plus a registered execute stage with valid/ready handshakes.
// Shifts run iteratively (SHIFT_STEP bits/cycle); define MULTICYCLE_ALU_MUL_EN for an iterative multiplier.
`default_nettype none

module multicycle_alu_unit #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic            opcodeb5,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            lt,
   output logic [2:0]      alu_ctrl,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

   localparam logic [2:0] C_ADD = 3'b000;
   localparam logic [2:0] C_SHL = 3'b001;
   localparam logic [2:0] C_SUB = 3'b010;
   localparam logic [2:0] C_MUL = 3'b011;
   localparam logic [2:0] C_XOR = 3'b100;
   localparam logic [2:0] C_SHR = 3'b101;
   localparam logic [2:0] C_OR  = 3'b110;
   localparam logic [2:0] C_AND = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [2:0]      dec_ctrl;
   logic            dec_illegal;
   logic            dec_multi;
   logic [XLEN-1:0] imm_result;
   logic            lt_now;
   logic            accept;

   logic [XLEN-1:0] work, work_nxt, exec_val;
   logic [CW-1:0]   remaining, rem_nxt, step;
   logic            exec_last;
   logic [2:0]      cap_ctrl;
   logic            cap_lt;

`ifdef MULTICYCLE_ALU_MUL_EN
   logic [XLEN-1:0] acc, acc_nxt, mulb;
`endif

   always_comb begin
      dec_ctrl    = C_ADD;
      dec_illegal = 1'b0;
      case (alu_op)
         2'b00: dec_ctrl = C_ADD;
         2'b01: dec_ctrl = C_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  dec_ctrl = (funct7b5 & opcodeb5) ? C_SUB : C_ADD;
               3'b001:  dec_ctrl = C_SHL;
               3'b100:  dec_ctrl = C_XOR;
               3'b101:  dec_ctrl = C_SHR;
               3'b110:  dec_ctrl = C_OR;
               3'b111:  dec_ctrl = C_AND;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: begin
`ifdef MULTICYCLE_ALU_MUL_EN
            if (funct3 == 3'b000) dec_ctrl = C_MUL;
            else                  dec_illegal = 1'b1;
`else
            dec_illegal = 1'b1;
`endif
         end
      endcase
   end

   // Shifts by zero finish immediately with the unshifted operand; multiply always iterates.
   always_comb begin
      dec_multi = 1'b0;
      if (!dec_illegal) begin
         if ((dec_ctrl == C_SHL || dec_ctrl == C_SHR) && src_b[SHW-1:0] != '0)
            dec_multi = 1'b1;
`ifdef MULTICYCLE_ALU_MUL_EN
         if (dec_ctrl == C_MUL)
            dec_multi = 1'b1;
`endif
      end
   end

   always_comb begin
      case (dec_ctrl)
         C_ADD:   imm_result = src_a + src_b;
         C_SUB:   imm_result = src_a - src_b;
         C_XOR:   imm_result = src_a ^ src_b;
         C_OR:    imm_result = src_a | src_b;
         C_AND:   imm_result = src_a & src_b;
         default: imm_result = src_a;
      endcase
      if (dec_illegal)
         imm_result = '0;
   end

   assign lt_now = $signed(src_a) < $signed(src_b);

   always_comb begin
      step     = (remaining > STEP_C) ? STEP_C : remaining;
      work_nxt = (cap_ctrl == C_SHL) ? (work << step) : (work >> step);
      exec_val = work_nxt;
`ifdef MULTICYCLE_ALU_MUL_EN
      acc_nxt = acc + (mulb[0] ? work : '0);
      if (cap_ctrl == C_MUL) begin
         step     = CW'(1);
         work_nxt = work << 1;
         exec_val = acc_nxt;
      end
`endif
      rem_nxt   = remaining - step;
      exec_last = (rem_nxt == '0);
   end

   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = dec_multi ? EXEC : DONE;
         EXEC: if (exec_last) state_nxt = DONE;
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_nxt = dec_multi ? EXEC : DONE;
               else          state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work      <= '0;
         remaining <= '0;
         cap_ctrl  <= C_ADD;
         cap_lt    <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
         acc       <= '0;
         mulb      <= '0;
`endif
      end else if (accept) begin
         work      <= src_a;
         remaining <= CW'(src_b[SHW-1:0]);
         cap_ctrl  <= dec_ctrl;
         cap_lt    <= lt_now;
`ifdef MULTICYCLE_ALU_MUL_EN
         acc       <= '0;
         mulb      <= src_b;
         if (dec_ctrl == C_MUL && !dec_illegal)
            remaining <= CW'(XLEN);
`endif
      end else if (state == EXEC) begin
         work      <= work_nxt;
         remaining <= rem_nxt;
`ifdef MULTICYCLE_ALU_MUL_EN
         acc       <= acc_nxt;
         mulb      <= mulb >> 1;
`endif
      end
   end

   // Visible outputs load only on entry into DONE, so they stay frozen under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         zero     <= 1'b0;
         lt       <= 1'b0;
         alu_ctrl <= 3'b000;
         illegal  <= 1'b0;
      end else if (accept && !dec_multi) begin
         result   <= imm_result;
         zero     <= (imm_result == '0);
         lt       <= lt_now;
         alu_ctrl <= dec_ctrl;
         illegal  <= dec_illegal;
      end else if (state == EXEC && exec_last) begin
         result   <= exec_val;
         zero     <= (exec_val == '0);
         lt       <= cap_lt;
         alu_ctrl <= cap_ctrl;
         illegal  <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: doc/multicycle_alu_unit.md
Name: multicycle_alu_unit

Overview:
- Parametrised successor to the team's combinational ALU decoder: merges ALU-control decode with a registered execute stage.
- Uses a valid/ready handshake on input and output.
- Logic/arithmetic ops complete in one cycle. Shifts run on an iterative barrel-free shifter, SHIFT_STEP bits per cycle.
- Sits between the control unit and writeback in the multicycle core variant.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥8.
- SHIFT_STEP, 1, bits shifted per EXEC cycle; power of two, ≤XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept request
- alu_op  input  2  00 load/store, 01 branch, 10 R/I-type, 11 extended
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- opcodeb5  input  1  opcode bit 5
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B; shift amount = src_b[log2(XLEN)-1:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- zero  output  1  result == 0
- lt  output  1  signed src_a < src_b (captured operands)
- alu_ctrl  output  3  latched decoded control code
- illegal  output  1  unsupported alu_op/funct3 combination

Behaviour:
- Decode codes (team encoding): 000 add, 010 sub, 001 shl, 100 xor, 101 shr (logical), 110 or, 111 and.
- alu_op 00 → add.
- alu_op 01 → sub for every funct3.
- alu_op 10 selects by funct3:
  - 000 → sub if funct7b5 & opcodeb5, else add.
  - 001 shl; 100 xor; 101 shr; 110 or; 111 and.
  - 010/011 → illegal.
- alu_op 11 → illegal (see optional feature).
- Handshake:
  - Request is accepted when in_valid & in_ready. Operands and decode are captured that cycle.
  - Result is transferred when out_valid & out_ready.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On accept, go to DONE if the op is non-shift/non-mul or shamt==0; otherwise go to EXEC.
  - EXEC: in_ready=0. Each cycle shifts the working register by min(SHIFT_STEP, remaining) and decrements remaining. Go to DONE when remaining reaches 0.
  - DONE: out_valid=1. result, zero, lt, alu_ctrl and illegal are held stable until out_ready.
  - DONE & out_ready & in_valid: back-to-back accept in the same cycle; next state follows the IDLE rules.
  - DONE & out_ready & !in_valid → IDLE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency (accept at cycle N):
  - Non-shift ops: out_valid at N+1.
  - Shifts: out_valid at N+1+ceil(shamt/SHIFT_STEP).
- Arithmetic:
  - add/sub are modulo 2^XLEN; carry is discarded.
  - Shift-in bits are 0.
  - lt is computed as a signed compare of the captured operands, independent of op.
- Illegal op: result=0, zero=1, illegal=1, latency 1 cycle. The FSM never hangs.
- Output registers change only on the transition into DONE. out_valid is low in IDLE and EXEC.
- Reset (async, any state, including mid-EXEC):
  - State → IDLE; pending op is discarded.
  - out_valid=0, in_ready=1 after release.
  - result=0, zero=0, lt=0, alu_ctrl=000, illegal=0.
- in_valid while in_ready=0 is ignored (no capture); the requester must hold it.

Optional Feature:
- MULTICYCLE_ALU_MUL_EN defined:
  - alu_op 11 with funct3 000 → multiply, low XLEN bits of src_a*src_b, alu_ctrl=011.
  - Implemented as iterative shift-add in EXEC, one bit per cycle, for exactly XLEN EXEC cycles.
  - out_valid at N+1+XLEN.
  - Other funct3 under alu_op 11 → illegal.
- Undefined: all alu_op 11 → illegal; no multiplier logic is synthesised.

Test Plan:
- Reset mid-op: alu_op=10, funct3=001, src_a=1, src_b=20; assert rst_n low 5 cycles after accept → immediately out_valid=0, result=0, in_ready=1 after release; no stale DONE.
- Add/sub (XLEN=32):
  - alu_op=10, funct3=000, funct7b5=1, opcodeb5=1, src_a=5, src_b=7 → next cycle out_valid=1, result=0xFFFFFFFE, alu_ctrl=010, lt=1, zero=0.
  - Same with opcodeb5=0 → result=12, alu_ctrl=000.
- Serial shift (SHIFT_STEP=1): alu_op=10, funct3=101, src_a=0x80000000, src_b=31 → out_valid exactly 32 cycles after accept, result=1. With SHIFT_STEP=4 → 9 cycles, result=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0.
  - Raise out_ready with new in_valid (alu_op=00, src_a=0x100, src_b=0x4) → same-cycle accept, next result=0x104.
- Illegal and branch:
  - alu_op=10, funct3=010 → illegal=1, result=0, zero=1, latency 1.
  - alu_op=01, src_a=src_b=9 → zero=1, alu_ctrl=010.
- MULTICYCLE_ALU_MUL_EN: alu_op=11, funct3=000, src_a=0xFFFFFFFF, src_b=3 → out_valid at N+33, result=0xFFFFFFFD. Without the macro → illegal=1 at N+1.
